// File: rtl/posit_pkg.sv
// Shared definitions for the posit warp scheduler: opcodes, datapath op
// encoding, FSM states, the queued command layout and small decode helpers.
package posit_pkg;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    localparam int BLOCKDIM_MAX = 16;

    typedef enum logic [1:0] {
        DP_ADD = 2'b00,
        DP_MUL = 2'b01,
        DP_DIV = 2'b10
    } dp_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rd;
        logic [4:0] blockdim;
    } cmd_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic dp_op_t op_to_dp(input logic [3:0] op);
        case (op)
            OP_MUL:  return DP_MUL;
            OP_DIV:  return DP_DIV;
            default: return DP_ADD;
        endcase
    endfunction

    // Lanes still holding elements for this warp, lowest lanes first.
    function automatic logic [3:0] lane_mask(input logic [4:0] rem);
        if (rem >= 5'd4) begin
            return 4'b1111;
        end
        case (rem[1:0])
            2'd3:    return 4'b0111;
            2'd2:    return 4'b0011;
            2'd1:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/posit_cmd_fifo.sv
// Small synchronous FIFO holding queued scheduler commands.
// Pushes into a full queue and pops from an empty one are ignored.
module posit_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/posit_warp_scheduler.sv
// Splits queued posit commands into warps of up to four elements and drives
// the 4-lane posit datapath one warp at a time, with a WAIT-state timeout.
module posit_warp_scheduler
    import posit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_op_i,
    input  logic [1:0] cmd_ra_i,
    input  logic [1:0] cmd_rb_i,
    input  logic [1:0] cmd_rd_i,
    input  logic       blockdim_we_i,
    input  logic [4:0] blockdim_i,
    input  logic       err_clr_i,
    output logic       dp_start_o,
    output logic [1:0] dp_op_o,
    output logic [1:0] dp_ra_o,
    output logic [1:0] dp_rb_o,
    output logic [1:0] dp_rd_o,
    output logic [1:0] dp_warp_o,
    output logic [3:0] dp_lane_en_o,
    input  logic       dp_done_i,
    output logic       busy_o,
    output logic       cmd_done_o,
    output logic       err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    warp;
    logic [1:0]    warp_next;
    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_cnt_next;
    logic [4:0]    shadow;
    logic          err_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    cmd_t          push_entry;
    cmd_t          head;
    logic [4:0]    rem;
    logic [2:0]    warp_inc;
    logic [4:0]    next_base;

    assign push        = cmd_valid_i && cmd_ready_o;
    assign cmd_ready_o = !fifo_full;
    assign busy_o      = (state != ST_IDLE);
    assign push_entry  = '{op: cmd_op_i, ra: cmd_ra_i, rb: cmd_rb_i, rd: cmd_rd_i, blockdim: shadow};
    assign rem         = head.blockdim - {1'b0, warp, 2'b00};
    assign warp_inc    = {1'b0, warp} + 3'd1;
    assign next_base   = {warp_inc, 2'b00};

    posit_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Blockdim shadow register; oversized element counts clamp to one full block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
        end else if (blockdim_we_i) begin
            shadow <= (blockdim_i > 5'(BLOCKDIM_MAX)) ? 5'(BLOCKDIM_MAX) : blockdim_i;
        end
    end

    // FSM state, warp index and WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            warp     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            warp     <= warp_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    // Next-state logic plus the start/done/pop strobes.
    always_comb begin
        state_next    = state;
        warp_next     = warp;
        wait_cnt_next = wait_cnt;
        err_set       = 1'b0;
        pop           = 1'b0;
        dp_start_o    = 1'b0;
        cmd_done_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    warp_next = '0;
                    if ((head.blockdim == 5'd0) || !op_is_valid(head.op)) begin
                        err_set    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                dp_start_o    = 1'b1;
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (dp_done_i) begin
                    state_next = ST_NEXT;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            ST_NEXT: begin
                warp_next  = warp_inc[1:0];
                state_next = (next_base < head.blockdim) ? ST_ISSUE : ST_DONE;
            end
            ST_DONE: begin
                cmd_done_o = 1'b1;
                pop        = 1'b1;
                warp_next  = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath operand bus, held from the head entry while a warp is in flight.
    always_comb begin
        dp_op_o      = '0;
        dp_ra_o      = '0;
        dp_rb_o      = '0;
        dp_rd_o      = '0;
        dp_warp_o    = '0;
        dp_lane_en_o = '0;
        if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
            dp_op_o      = op_to_dp(head.op);
            dp_ra_o      = head.ra;
            dp_rb_o      = head.rb;
            dp_rd_o      = head.rd;
            dp_warp_o    = warp;
            dp_lane_en_o = lane_mask(rem);
        end
    end

endmodule

// File: tb/tb_posit_warp_scheduler.sv
// Self-checking bench for posit_warp_scheduler: per-feature tasks compared
// against a command-level reference model of warps and lane masks.
module tb_posit_warp_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct {
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rd;
        int         bd;
    } cmd_s;

    typedef struct {
        logic [1:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rd;
        logic [1:0] warp;
        logic [3:0] lanes;
        int         cyc;
    } start_s;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [3:0] cmd_op_i;
    logic [1:0] cmd_ra_i;
    logic [1:0] cmd_rb_i;
    logic [1:0] cmd_rd_i;
    logic       blockdim_we_i;
    logic [4:0] blockdim_i;
    logic       err_clr_i;
    logic       dp_start_o;
    logic [1:0] dp_op_o;
    logic [1:0] dp_ra_o;
    logic [1:0] dp_rb_o;
    logic [1:0] dp_rd_o;
    logic [1:0] dp_warp_o;
    logic [3:0] dp_lane_en_o;
    logic       dp_done_i;
    logic       busy_o;
    logic       cmd_done_o;
    logic       err_o;

    cmd_s   model_q[$];
    start_s obs[$];
    start_s exp_q[$];
    int     done_cyc[$];
    start_s cur;
    int     cycle;
    int     done_delay;
    int     done_cd;
    int     stab_bad;
    int     shadow_model;
    logic   ready_now;
    int     checks;
    int     fails;

    always #5 clk = ~clk;

    posit_warp_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_ra_i      (cmd_ra_i),
        .cmd_rb_i      (cmd_rb_i),
        .cmd_rd_i      (cmd_rd_i),
        .blockdim_we_i (blockdim_we_i),
        .blockdim_i    (blockdim_i),
        .err_clr_i     (err_clr_i),
        .dp_start_o    (dp_start_o),
        .dp_op_o       (dp_op_o),
        .dp_ra_o       (dp_ra_o),
        .dp_rb_o       (dp_rb_o),
        .dp_rd_o       (dp_rd_o),
        .dp_warp_o     (dp_warp_o),
        .dp_lane_en_o  (dp_lane_en_o),
        .dp_done_i     (dp_done_i),
        .busy_o        (busy_o),
        .cmd_done_o    (cmd_done_o),
        .err_o         (err_o)
    );

    // One clock cycle: sample at the falling edge, record activity, play the datapath.
    task automatic step();
        start_s s;
        @(negedge clk);
        cycle++;
        ready_now = cmd_ready_o;
        if (dp_start_o) begin
            s.op = dp_op_o; s.ra = dp_ra_o; s.rb = dp_rb_o; s.rd = dp_rd_o;
            s.warp = dp_warp_o; s.lanes = dp_lane_en_o; s.cyc = cycle;
            obs.push_back(s);
            cur = s;
        end else if (busy_o && dp_lane_en_o != 4'b0000) begin
            if ({dp_op_o, dp_ra_o, dp_rb_o, dp_rd_o, dp_warp_o, dp_lane_en_o} !==
                {cur.op, cur.ra, cur.rb, cur.rd, cur.warp, cur.lanes}) begin
                stab_bad++;
            end
        end
        if (cmd_done_o) begin
            done_cyc.push_back(cycle);
        end
        dp_done_i = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) dp_done_i = 1'b1;
        end
        if (dp_start_o && done_delay > 0) begin
            done_cd = done_delay;
        end
    endtask

    task automatic set_blockdim(input int v);
        blockdim_we_i = 1'b1;
        blockdim_i    = 5'(v);
        step();
        blockdim_we_i = 1'b0;
        shadow_model  = (v > 16) ? 16 : v;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [1:0] rd, output bit acc);
        cmd_valid_i = 1'b1;
        cmd_op_i = op; cmd_ra_i = ra; cmd_rb_i = rb; cmd_rd_i = rd;
        acc = ready_now;
        if (acc) model_q.push_back('{op, ra, rb, rd, shadow_model});
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic push_retry(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                              input logic [1:0] rd, output int acc_cycle);
        bit acc = 1'b0;
        int tries = 0;
        acc_cycle = -1;
        while (!acc && tries < 200) begin
            acc_cycle = cycle;
            push_cmd(op, ra, rb, rd, acc);
            tries++;
        end
        if (!acc) acc_cycle = -1;
    endtask

    task automatic run_until(input int n_done, input int max_cycles);
        int lim = cycle + max_cycles;
        while (done_cyc.size() < n_done && cycle < lim) step();
        step();
        step();
    endtask

    task automatic clean_start();
        rst = 1'b0; cmd_valid_i = 1'b0; blockdim_we_i = 1'b0; err_clr_i = 1'b0; dp_done_i = 1'b0;
        done_cd = 0;
        step();
        step();
        rst = 1'b1; done_cd = 0; done_delay = 3; shadow_model = 0; stab_bad = 0;
        model_q.delete(); obs.delete(); done_cyc.delete();
        step();
    endtask

    // Reference model: each valid command yields ceil(bd/4) warps with the remaining-element lane mask.
    function automatic void build_expected();
        start_s e;
        exp_q.delete();
        foreach (model_q[k]) begin
            if ((model_q[k].op >= 4'd3 && model_q[k].op <= 4'd5) && model_q[k].bd != 0) begin
                for (int w = 0; w < (model_q[k].bd + 3) / 4; w++) begin
                    int r = model_q[k].bd - 4 * w;
                    e.op = 2'(model_q[k].op - 4'd3);
                    e.ra = model_q[k].ra; e.rb = model_q[k].rb; e.rd = model_q[k].rd;
                    e.warp = 2'(w);
                    e.lanes = (r >= 4) ? 4'hF : 4'((1 << r) - 1);
                    e.cyc = 0;
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    function automatic bit expected_err();
        foreach (model_q[k]) begin
            if (!(model_q[k].op >= 4'd3 && model_q[k].op <= 4'd5) || model_q[k].bd == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready_o); end
        checks++;
        if ({busy_o, cmd_done_o, err_o, dp_start_o} !== 4'b0000) begin
            fails++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy_o, cmd_done_o, err_o, dp_start_o});
        end
        checks++;
        if ({dp_op_o, dp_ra_o, dp_rb_o, dp_rd_o, dp_warp_o, dp_lane_en_o} !== 14'd0) begin
            fails++; $display("[TB] FAIL reset_dp_bus: got %h want 0",
                              {dp_op_o, dp_ra_o, dp_rb_o, dp_rd_o, dp_warp_o, dp_lane_en_o});
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit acc;
        int c;
        logic [3:0] exp_l [3];
        exp_l = '{4'hF, 4'hF, 4'h3};
        clean_start();
        set_blockdim(10);
        done_delay = 3;
        c = cycle;
        push_cmd(4'b0011, 2'd1, 2'd2, 2'd3, acc);
        run_until(1, 200);
        checks++;
        if (acc !== 1'b1) begin fails++; $display("[TB] FAIL basic_accept: got %b want 1", acc); end
        checks++;
        if (obs.size() != 3) begin fails++; $display("[TB] FAIL basic_starts: got %0d want 3", obs.size()); end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            checks++;
            if ({obs[i].op, obs[i].ra, obs[i].rb, obs[i].rd, obs[i].warp, obs[i].lanes} !==
                {2'b00, 2'd1, 2'd2, 2'd3, 2'(i), exp_l[i]}) begin
                fails++;
                $display("[TB] FAIL basic_warp%0d: got warp %0d lanes %b want warp %0d lanes %b",
                         i, obs[i].warp, obs[i].lanes, i, exp_l[i]);
            end
        end
        if (obs.size() >= 1) begin
            checks++;
            if (obs[0].cyc != c + 2) begin
                fails++; $display("[TB] FAIL basic_latency: got %0d want %0d", obs[0].cyc - c, 2);
            end
        end
        if (obs.size() >= 2) begin
            checks++;
            if (obs[1].cyc - obs[0].cyc != 5) begin
                fails++; $display("[TB] FAIL basic_spacing: got %0d want 5", obs[1].cyc - obs[0].cyc);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin fails++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cyc.size()); end
        checks++;
        if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_err: got %b want 0", err_o); end
        checks++;
        if (stab_bad != 0) begin fails++; $display("[TB] FAIL basic_stable: got %0d changes want 0", stab_bad); end
    endtask

    task automatic test_errors();
        bit acc;
        int lim;
        clean_start();
        set_blockdim(0);
        push_cmd(4'b0011, 2'd0, 2'd1, 2'd2, acc);
        run_until(1, 50);
        checks++;
        if ({acc, obs.size() == 0, done_cyc.size() == 1, err_o} !== 4'b1111) begin
            fails++; $display("[TB] FAIL err_bd0: got acc/nostart/done/err %b want 1111",
                              {acc, obs.size() == 0, done_cyc.size() == 1, err_o});
        end
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0; step();
        checks++;
        if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL err_clear: got %b want 0", err_o); end
        done_cyc.delete();
        set_blockdim(8);
        push_cmd(4'b1111, 2'd0, 2'd1, 2'd2, acc);
        run_until(1, 50);
        checks++;
        if ({acc, obs.size() == 0, done_cyc.size() == 1, err_o} !== 4'b1111) begin
            fails++; $display("[TB] FAIL err_badop: got acc/nostart/done/err %b want 1111",
                              {acc, obs.size() == 0, done_cyc.size() == 1, err_o});
        end
        done_cyc.delete();
        err_clr_i = 1'b1;
        push_cmd(4'b0000, 2'd0, 2'd1, 2'd2, acc);
        lim = cycle + 50;
        while (done_cyc.size() == 0 && cycle < lim) step();
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("[TB] FAIL err_set_wins: got %b want 1", err_o); end
        step();
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL err_clear_after: got %b want 0", err_o); end
    endtask

    task automatic test_timeout_full();
        bit acc;
        int acc5;
        int c0;
        clean_start();
        done_delay = -1;
        set_blockdim(4);
        for (int i = 0; i < 4; i++) push_retry(4'b0100, 2'(i), 2'd1, 2'd2, c0);
        checks++;
        if (ready_now !== 1'b0) begin fails++; $display("[TB] FAIL full_ready_low: got %b want 0", ready_now); end
        push_retry(4'b0101, 2'd3, 2'd3, 2'd3, acc5);
        checks++;
        if (done_cyc.size() < 1 || acc5 != done_cyc[0] + 1) begin
            fails++; $display("[TB] FAIL full_ready_rise: got accept cycle %0d want first done + 1 (%0d)",
                              acc5, (done_cyc.size() > 0) ? done_cyc[0] + 1 : -1);
        end
        run_until(5, 300);
        checks++;
        if (obs.size() != 5 || done_cyc.size() != 5) begin
            fails++; $display("[TB] FAIL tmo_counts: got starts %0d dones %0d want 5 5", obs.size(), done_cyc.size());
        end
        if (obs.size() >= 2 && done_cyc.size() >= 1) begin
            checks++;
            if (done_cyc[0] - obs[0].cyc != TMO + 1) begin
                fails++; $display("[TB] FAIL tmo_latency: got %0d want %0d", done_cyc[0] - obs[0].cyc, TMO + 1);
            end
            checks++;
            if (obs[1].cyc != done_cyc[0] + 2 || obs[1].warp !== 2'd0 || obs[1].lanes !== 4'hF) begin
                fails++; $display("[TB] FAIL tmo_restart: got cycle %0d warp %0d lanes %b want %0d 0 1111",
                                  obs[1].cyc, obs[1].warp, obs[1].lanes, done_cyc[0] + 2);
            end
        end
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("[TB] FAIL tmo_err: got %b want 1", err_o); end
        acc = ready_now;
        checks++;
        if ({acc, busy_o} !== 2'b10) begin fails++; $display("[TB] FAIL tmo_drained: got ready/busy %b want 10", {acc, busy_o}); end
    endtask

    task automatic test_shadow();
        bit acc;
        int lim;
        clean_start();
        done_delay = 2;
        set_blockdim(16);
        push_cmd(4'b0011, 2'd1, 2'd1, 2'd1, acc);
        lim = cycle + 50;
        while (obs.size() == 0 && cycle < lim) step();
        set_blockdim(4);
        push_cmd(4'b0100, 2'd2, 2'd2, 2'd2, acc);
        set_blockdim(25);
        push_cmd(4'b0101, 2'd3, 2'd0, 2'd1, acc);
        run_until(3, 400);
        build_expected();
        checks++;
        if (obs.size() != 9 || exp_q.size() != 9) begin
            fails++; $display("[TB] FAIL shadow_starts: got %0d model %0d want 9", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs[i].op, obs[i].ra, obs[i].rb, obs[i].rd, obs[i].warp, obs[i].lanes} !==
                {exp_q[i].op, exp_q[i].ra, exp_q[i].rb, exp_q[i].rd, exp_q[i].warp, exp_q[i].lanes}) begin
                fails++; $display("[TB] FAIL shadow_start%0d: got warp %0d lanes %b want warp %0d lanes %b",
                                  i, obs[i].warp, obs[i].lanes, exp_q[i].warp, exp_q[i].lanes);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int acc_c;
        int n_acc;
        int bad;
        logic [3:0] op;
        clean_start();
        for (int it = 0; it < 25; it++) begin
            model_q.delete(); obs.delete(); done_cyc.delete(); stab_bad = 0;
            done_delay = $urandom_range(1, 5);
            n = $urandom_range(1, 3);
            n_acc = 0;
            for (int k = 0; k < n; k++) begin
                set_blockdim($urandom_range(0, 31));
                op = ($urandom_range(0, 9) < 8) ? 4'(3 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
                push_retry(op, 2'($urandom), 2'($urandom), 2'($urandom), acc_c);
                if (acc_c >= 0) n_acc++;
            end
            run_until(n, 600);
            build_expected();
            bad = 0;
            if (obs.size() != exp_q.size()) bad++;
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                if ({obs[i].op, obs[i].ra, obs[i].rb, obs[i].rd, obs[i].warp, obs[i].lanes} !==
                    {exp_q[i].op, exp_q[i].ra, exp_q[i].rb, exp_q[i].rd, exp_q[i].warp, exp_q[i].lanes}) bad++;
            end
            checks++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL rand%0d_starts: got %0d starts (%0d differ) want %0d",
                                  it, obs.size(), bad, exp_q.size());
            end
            checks++;
            if (n_acc != n || done_cyc.size() != n) begin
                fails++; $display("[TB] FAIL rand%0d_done: got accepted %0d done %0d want %0d", it, n_acc, done_cyc.size(), n);
            end
            checks++;
            if (err_o !== expected_err() || stab_bad != 0) begin
                fails++; $display("[TB] FAIL rand%0d_err_stable: got err %b changes %0d want err %b changes 0",
                                  it, err_o, stab_bad, expected_err());
            end
            err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        end
    endtask

    task automatic test_reset_midflight();
        bit acc;
        int lim;
        clean_start();
        done_delay = 3;
        set_blockdim(8);
        push_cmd(4'b0011, 2'd1, 2'd2, 2'd3, acc);
        push_cmd(4'b0100, 2'd1, 2'd2, 2'd3, acc);
        lim = cycle + 100;
        while (obs.size() < 2 && cycle < lim) step();
        step();
        checks++;
        if ({busy_o, dp_warp_o} !== 3'b101) begin
            fails++; $display("[TB] FAIL midrst_in_wait: got busy/warp %b want 101", {busy_o, dp_warp_o});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({busy_o, cmd_ready_o, cmd_done_o} !== 3'b010 || done_cyc.size() != 0) begin
            fails++; $display("[TB] FAIL midrst_state: got busy/ready/done %b dones %0d want 010 0",
                              {busy_o, cmd_ready_o, cmd_done_o}, done_cyc.size());
        end
        rst = 1'b1; done_cd = 0; dp_done_i = 1'b0;
        obs.delete(); done_cyc.delete();
        repeat (30) step();
        checks++;
        if (obs.size() != 0 || done_cyc.size() != 0 || busy_o !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_queue_empty: got starts %0d dones %0d busy %b want 0 0 0",
                              obs.size(), done_cyc.size(), busy_o);
        end
    endtask

    initial begin
        rst = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_ra_i = '0; cmd_rb_i = '0; cmd_rd_i = '0;
        blockdim_we_i = 1'b0; blockdim_i = '0; err_clr_i = 1'b0; dp_done_i = 1'b0;
        cycle = 0; done_delay = 3; done_cd = 0; stab_bad = 0; shadow_model = 0;
        ready_now = 1'b0; checks = 0; fails = 0;
        cur = '{2'b0, 2'b0, 2'b0, 2'b0, 2'b0, 4'b0, 0};
        $display("[TB] starting posit_warp_scheduler bench");
        test_reset();
        test_basic();
        test_errors();
        test_timeout_full();
        test_shadow();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
